// File: rtl/sram_sp_ctrl_pkg.sv
// rtl/sram_sp_ctrl_pkg.sv - shared constants and FSM state type (SRAM_CTRL_ZERO_INIT_EN adds ST_INIT)
package sram_sp_ctrl_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_ADDR_W = 5;

`ifdef SRAM_CTRL_ZERO_INIT_EN
    typedef enum logic [0:0] {
        ST_INIT,
        ST_IDLE
    } ctrl_state_t;
`else
    typedef enum logic [0:0] {
        ST_IDLE
    } ctrl_state_t;
`endif

endpackage

// File: rtl/sram_sp_ctrl_if.sv
// rtl/sram_sp_ctrl_if.sv - write/read request and read response handshakes
interface sram_sp_ctrl_if
    import sram_sp_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              w_valid;
    logic              w_ready;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              r_valid;
    logic              r_ready;
    logic [ADDR_W-1:0] r_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;

    modport master (
        output w_valid, w_addr, w_data, r_valid, r_addr, resp_ready,
        input  w_ready, r_ready, resp_valid, resp_data
    );

    modport slave (
        input  w_valid, w_addr, w_data, r_valid, r_addr, resp_ready,
        output w_ready, r_ready, resp_valid, resp_data
    );

endinterface

// File: rtl/sram_resp_fifo.sv
// rtl/sram_resp_fifo.sv - 2-entry in-order read response buffer
module sram_resp_fifo
    import sram_sp_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              s_tvalid,
    input  logic [DATA_W-1:0] s_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [1:0]        level
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              pop;

    // Head entry is read straight from storage, so it holds while not popped
    assign m_tvalid = (level != 2'd0);
    assign m_tdata  = mem[rd_ptr];
    assign pop      = m_tvalid && m_tready;

    // Pointer and occupancy bookkeeping; the controller never pushes when full
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            level  <= 2'd0;
        end else begin
            if (s_tvalid) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            level <= level + {1'b0, s_tvalid} - {1'b0, pop};
        end
    end

    // Data storage needs no reset; validity is tracked by level
    always_ff @(posedge clock) begin
        if (s_tvalid) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

endmodule

// File: rtl/sram_sp_ctrl.sv
// rtl/sram_sp_ctrl.sv - single-port SRAM controller, optional zero sweep via SRAM_CTRL_ZERO_INIT_EN
module sram_sp_ctrl
    import sram_sp_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    sram_sp_ctrl_if.slave     bus,
    output logic              init_done,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);

    ctrl_state_t state;
    logic        rd_inflight;
    logic        pref_rd;
    logic [1:0]  fifo_level;
    logic [2:0]  occupancy;
    logic        deq;
    logic        w_ok;
    logic        r_ok;
    logic        contend;
    logic        grant_w;
    logic        grant_r;
`ifdef SRAM_CTRL_ZERO_INIT_EN
    logic [ADDR_W-1:0] init_addr;
`endif

    // A read may issue only if its response is guaranteed a buffer slot
    assign deq       = bus.resp_valid && bus.resp_ready;
    assign occupancy = {1'b0, fifo_level} + {2'b00, rd_inflight};
    assign w_ok      = init_done && !reset;
    assign r_ok      = init_done && !reset && (occupancy < (3'd2 + {2'b00, deq}));

    // Readies are mutually exclusive when both sides request; pref_rd picks the winner
    assign bus.w_ready = w_ok && !(bus.r_valid && r_ok && pref_rd);
    assign bus.r_ready = r_ok && !(bus.w_valid && w_ok && !pref_rd);
    assign grant_w     = bus.w_valid && bus.w_ready;
    assign grant_r     = bus.r_valid && bus.r_ready;
    assign contend     = bus.w_valid && bus.r_valid && w_ok && r_ok;

    // Bring-up sequencing: optional zero sweep, then open the request ports
    always_ff @(posedge clock) begin
        if (reset) begin
`ifdef SRAM_CTRL_ZERO_INIT_EN
            state     <= ST_INIT;
            init_addr <= '0;
`else
            state     <= ST_IDLE;
`endif
            init_done <= 1'b0;
        end else begin
`ifdef SRAM_CTRL_ZERO_INIT_EN
            case (state)
                ST_INIT: begin
                    init_addr <= init_addr + 1'b1;
                    if (init_addr == ADDR_W'(DEPTH - 1)) begin
                        state     <= ST_IDLE;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
`else
            init_done <= (state == ST_IDLE);
`endif
        end
    end

    // Track the read whose data appears on sram_q next cycle, and flip priority on contention
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_inflight <= 1'b0;
            pref_rd     <= 1'b0;
        end else begin
            rd_inflight <= grant_r;
            if (contend) begin
                pref_rd <= ~pref_rd;
            end
        end
    end

    // Macro pins are driven in the grant cycle and sampled by the macro on the closing edge
    always_comb begin
        sram_ceb = 1'b1;
        sram_web = 1'b1;
        sram_a   = '0;
        sram_d   = '0;
        if (!reset) begin
`ifdef SRAM_CTRL_ZERO_INIT_EN
            if (state == ST_INIT) begin
                sram_ceb = 1'b0;
                sram_web = 1'b0;
                sram_a   = init_addr;
            end else
`endif
            if (grant_w) begin
                sram_ceb = 1'b0;
                sram_web = 1'b0;
                sram_a   = bus.w_addr;
                sram_d   = bus.w_data;
            end else if (grant_r) begin
                sram_ceb = 1'b0;
                sram_a   = bus.r_addr;
            end
        end
    end

    sram_resp_fifo #(
        .DATA_W (DATA_W)
    ) u_resp_fifo (
        .clock    (clock),
        .reset    (reset),
        .s_tvalid (rd_inflight),
        .s_tdata  (sram_q),
        .m_tvalid (bus.resp_valid),
        .m_tready (bus.resp_ready),
        .m_tdata  (bus.resp_data),
        .level    (fifo_level)
    );

endmodule

// File: tb/tb_sram_sp_ctrl.sv
// tb/tb_sram_sp_ctrl.sv - directed self-checking bench for sram_sp_ctrl (honours SRAM_CTRL_ZERO_INIT_EN)
module tb_sram_sp_ctrl;
    import sram_sp_ctrl_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

`ifdef SRAM_CTRL_ZERO_INIT_EN
    localparam int            EXP_INIT   = 32;
    localparam logic [DW-1:0] EXP_ADDR7  = 32'h0000_0000;
    localparam logic [DW-1:0] EXP_ADDR20 = 32'h0000_0000;
`else
    localparam int            EXP_INIT   = 1;
    localparam logic [DW-1:0] EXP_ADDR7  = 32'hBAD0_0007;
    localparam logic [DW-1:0] EXP_ADDR20 = 32'hBAD0_0014;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          init_done;
    logic          sram_ceb;
    logic          sram_web;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] model_q;
    logic [DW-1:0] noise;
    logic          noise_en;

    int total = 0;
    int bad   = 0;

    sram_sp_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    sram_sp_ctrl #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.slave),
        .init_done (init_done),
        .sram_ceb  (sram_ceb),
        .sram_web  (sram_web),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    always #5 clock = ~clock;

    // Behavioural macro with registered read output; reset reloads a non-zero pattern
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                model_mem[i] <= 32'hBAD0_0000 | 32'(i);
            end
        end else if (!sram_ceb) begin
            if (!sram_web) begin
                model_mem[sram_a] <= sram_d;
            end else begin
                model_q <= model_mem[sram_a];
            end
        end
    end

    assign sram_q = noise_en ? noise : model_q;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc;

        reset = 1'b1;
        noise_en = 1'b0;
        noise = '0;
        bus.w_valid = 1'b1;
        bus.r_valid = 1'b1;
        bus.w_addr = '0;
        bus.w_data = '0;
        bus.r_addr = '0;
        bus.resp_ready = 1'b0;
        repeat (3) tick();
        #1;
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        chk("rst_init_done", 64'(init_done), 64'(0));
        chk("rst_ceb", 64'(sram_ceb), 64'(1));
        chk("rst_web", 64'(sram_web), 64'(1));
        chk("rst_w_ready", 64'(bus.w_ready), 64'(0));
        chk("rst_r_ready", 64'(bus.r_ready), 64'(0));

        bus.w_valid = 1'b0;
        bus.r_valid = 1'b0;
        reset = 1'b0;
        #1;
        n = 0;
        while (!init_done && n < 200) begin
`ifdef SRAM_CTRL_ZERO_INIT_EN
            chk("sweep_addr", 64'(sram_a), 64'(n));
            chk("sweep_web", 64'(sram_web), 64'(0));
`endif
            tick();
            n++;
        end
        chk("init_latency", 64'(n), 64'(EXP_INIT));

        bus.resp_ready = 1'b1;
        bus.r_valid = 1'b1;
        bus.r_addr = 5'd7;
        #1;
        chk("rd7_r_ready", 64'(bus.r_ready), 64'(1));
        chk("rd7_ceb", 64'(sram_ceb), 64'(0));
        chk("rd7_web", 64'(sram_web), 64'(1));
        chk("rd7_addr", 64'(sram_a), 64'(7));
        tick();
        bus.r_valid = 1'b0;
        #1;
        chk("rd7_resp_early", 64'(bus.resp_valid), 64'(0));
        tick();
        chk("rd7_resp_valid", 64'(bus.resp_valid), 64'(1));
        chk("rd7_data", 64'(bus.resp_data), 64'(EXP_ADDR7));
        tick();
        chk("rd7_drained", 64'(bus.resp_valid), 64'(0));

        bus.w_valid = 1'b1;
        bus.w_addr = 5'd3;
        bus.w_data = 32'hDEAD_BEEF;
        #1;
        chk("wr3_w_ready", 64'(bus.w_ready), 64'(1));
        chk("wr3_web", 64'(sram_web), 64'(0));
        chk("wr3_addr", 64'(sram_a), 64'(3));
        chk("wr3_d", 64'(sram_d), 64'(32'hDEAD_BEEF));
        tick();
        bus.w_valid = 1'b0;
        bus.r_valid = 1'b1;
        bus.r_addr = 5'd3;
        #1;
        chk("raw3_r_ready", 64'(bus.r_ready), 64'(1));
        tick();
        bus.r_valid = 1'b0;
        #1;
        chk("raw3_resp_early", 64'(bus.resp_valid), 64'(0));
        tick();
        chk("raw3_resp_valid", 64'(bus.resp_valid), 64'(1));
        chk("raw3_data", 64'(bus.resp_data), 64'(32'hDEAD_BEEF));
        tick();

        for (int k = 0; k < 4; k++) begin
            bus.w_valid = 1'b1;
            bus.r_valid = 1'b1;
            bus.w_addr = 5'd5;
            bus.w_data = 32'h1111_0000 + 32'(k);
            bus.r_addr = 5'd3;
            #1;
            chk("arb_web", 64'(sram_web), ((k % 2) == 0) ? 64'd0 : 64'd1);
            chk("arb_ceb", 64'(sram_ceb), 64'(0));
            tick();
        end
        bus.w_valid = 1'b0;
        bus.r_valid = 1'b0;
        repeat (3) tick();
        chk("arb_drained", 64'(bus.resp_valid), 64'(0));

        bus.resp_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            bus.r_valid = 1'b1;
            bus.r_addr = (k == 0) ? 5'd5 : ((k == 1) ? 5'd3 : 5'd7);
            #1;
            if (bus.r_ready) begin
                acc++;
            end
            tick();
        end
        chk("bp_accepted", 64'(acc), 64'(2));
        chk("bp_r_ready_low", 64'(bus.r_ready), 64'(0));
        chk("bp_hold_valid", 64'(bus.resp_valid), 64'(1));
        chk("bp_hold_data", 64'(bus.resp_data), 64'(32'h1111_0002));
        bus.r_valid = 1'b0;
        bus.resp_ready = 1'b1;
        tick();
        chk("bp_second_valid", 64'(bus.resp_valid), 64'(1));
        chk("bp_second_data", 64'(bus.resp_data), 64'(32'hDEAD_BEEF));
        tick();
        chk("bp_drained", 64'(bus.resp_valid), 64'(0));

        noise_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            noise = $urandom;
            #1;
            chk("idle_resp_valid", 64'(bus.resp_valid), 64'(0));
            chk("idle_ceb", 64'(sram_ceb), 64'(1));
            chk("idle_web", 64'(sram_web), 64'(1));
            tick();
        end
        noise_en = 1'b0;

        bus.r_valid = 1'b1;
        bus.r_addr = 5'd3;
        #1;
        chk("mrr_r_ready", 64'(bus.r_ready), 64'(1));
        tick();
        bus.r_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("mrr_ceb", 64'(sram_ceb), 64'(1));
        tick();
        reset = 1'b0;
        #1;
        chk("mrr_init_done", 64'(init_done), 64'(0));
        for (int k = 0; k < 3; k++) begin
            chk("mrr_resp_valid", 64'(bus.resp_valid), 64'(0));
            tick();
        end

`ifdef SRAM_CTRL_ZERO_INIT_EN
        n = 0;
        while (!(sram_a == 5'd10 && !sram_ceb) && n < 100) begin
            tick();
            n++;
        end
        chk("msr_found_addr10", 64'(sram_a), 64'(10));
        reset = 1'b1;
        #1;
        chk("msr_ceb", 64'(sram_ceb), 64'(1));
        tick();
        reset = 1'b0;
        #1;
        chk("msr_restart_addr", 64'(sram_a), 64'(0));
        chk("msr_restart_ceb", 64'(sram_ceb), 64'(0));
        n = 0;
        while (!init_done && n < 200) begin
            tick();
            n++;
        end
        chk("msr_latency", 64'(n), 64'(32));
`else
        n = 0;
        while (!init_done && n < 200) begin
            tick();
            n++;
        end
        chk("rerelease_ready", 64'(init_done), 64'(1));
`endif

        bus.r_valid = 1'b1;
        bus.r_addr = 5'd20;
        #1;
        chk("rd20_r_ready", 64'(bus.r_ready), 64'(1));
        tick();
        bus.r_valid = 1'b0;
        tick();
        chk("rd20_resp_valid", 64'(bus.resp_valid), 64'(1));
        chk("rd20_data", 64'(bus.resp_data), 64'(EXP_ADDR20));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_sp_ctrl.md
SRAM_SP_CTRL -- requirements
Module: sram_sp_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the word width.
REQ-002 Parameter DEPTH, default 32, SHALL set the word count.
REQ-003 Parameter ADDR_W, default 5, SHALL equal clog2(DEPTH).
REQ-004 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  SHALL be synchronous and active-high.
REQ-006 w_valid/w_ready  in/out  1/1  SHALL form the write-request handshake.
REQ-007 w_addr/w_data  in  ADDR_W/DATA_W  SHALL carry the write address and data.
REQ-008 r_valid/r_ready  in/out  1/1  SHALL form the read-request handshake.
REQ-009 r_addr  in  ADDR_W  SHALL carry the read address.
REQ-010 resp_valid/resp_ready  out/in  1/1  SHALL form the read-response handshake.
REQ-011 resp_data  out  DATA_W  SHALL carry the read data.
REQ-012 init_done  out  1  SHALL indicate that the block accepts requests.
REQ-013 sram_ceb/sram_web  out  1/1  SHALL be the macro's active-low chip-enable and write-enable.
REQ-014 sram_a/sram_d  out  ADDR_W/DATA_W  SHALL be the macro address and write data.
REQ-015 sram_q  in  DATA_W  SHALL be the macro's registered read output.

Function
REQ-016 Macro access SHALL be driven combinationally in the grant cycle and sampled by the macro on the closing edge E.
REQ-017 Only E+1 sram_q SHALL be captured, and only after a read; sram_q SHALL be ignored otherwise.
REQ-018 At most one access (write or read) SHALL be granted per cycle.
REQ-019 When both requests are valid, the grant SHALL alternate: the opposite type to the last contended grant wins, and write wins first after reset.
REQ-020 Read data SHALL pass through a 2-entry in-order response buffer; resp_valid SHALL rise the cycle after capture.
REQ-021 r_ready SHALL be 0 unless (buffer entries + in-flight reads - dequeue this cycle) < 2.
REQ-022 With resp_ready held 1, reads SHALL sustain one per cycle, with 2-cycle request-to-resp_valid latency.
REQ-023 A read granted the cycle after a write to the same address SHALL return the new data.
REQ-024 An idle cycle SHALL drive sram_ceb=1 and sram_web=1.
REQ-025 resp_data SHALL hold stable while resp_valid=1 and resp_ready=0.
REQ-026 w_ready and r_ready SHALL be 0 while init_done=0.

Reset
REQ-027 Reset SHALL clear resp_valid, init_done, the buffer, the in-flight flag and the arbitration flag, and SHALL force sram_ceb=1 and sram_web=1.
REQ-028 Reset asserted mid-sweep or mid-read SHALL discard all in-flight state and restart from the first post-reset state.

Configuration
REQ-029 With SRAM_CTRL_ZERO_INIT_EN defined, the FSM SHALL use states INIT then IDLE.
REQ-030 In INIT, the block SHALL write 0 to addresses 0..DEPTH-1, one per cycle, and SHALL set init_done on the cycle after address DEPTH-1.
REQ-031 Without SRAM_CTRL_ZERO_INIT_EN, there SHALL be no INIT state, and init_done SHALL be 1 on the first cycle after reset deasserts.

Structure
REQ-032 A shared package SHALL hold the FSM state enum and the default DATA_W/DEPTH/ADDR_W constants.
REQ-033 The response buffer SHALL be one sub-module, sram_resp_fifo (2-entry, valid/ready).
REQ-034 The macro SHALL be instantiated outside this block.

Verification
REQ-035 Reset, then idle with ZERO_INIT_EN -> init_done=1 exactly 32 cycles after reset release; read address 7 -> resp_data=0.
REQ-036 Write 0xDEADBEEF to address 3, then read address 3 the next cycle -> resp_data=0xDEADBEEF two cycles after the read grant.
REQ-037 Both valid for 4 cycles -> grants in the order W,R,W,R.
REQ-038 resp_ready=0 with reads streamed -> exactly 2 reads accepted, r_ready=0 afterward, and both data returned in order once resp_ready=1.
REQ-039 Reset pulsed at sweep address 10 -> sweep restarts at address 0, and init_done rises 32 cycles after release.
REQ-040 Idle cycles with random sram_q -> resp_valid stays 0.
